top_ram: RTL and testbench

- Top-level DMA loopback block: an AXI4-Lite slave register file configures a DMA engine.
- The MM2S side reads 128-bit words from an external memory through a simple RAM read port (1-cycle read latency).
- The S2MM side writes the same words back to a second memory region through a RAM write port with byte strobes.
- Software programs source/destination addresses and byte count, sets start, then polls done.

---
 rtl/top_ram.sv | 181 ++++++++++++++++++
 tb/tb_top_ram.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_ram.sv
// DMA loopback: AXI4-Lite register file drives a copy engine that streams
// 128-bit words from a RAM read port back out to a byte-strobed RAM write port.
module top_ram #(
  parameter int AXIL_ADDR_WIDTH = 40,
  parameter int DATA_WR_WIDTH   = 32,
  parameter int STRB_WIDTH      = 4,
  parameter int DATA_RD_WIDTH   = 32,
  parameter int AXI_WIDTH       = 128,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int LSB             = $clog2(AXI_WIDTH) - 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXIL_ADDR_WIDTH-1:0]    s_axil_awaddr,
  input  logic [2:0]                    s_axil_awprot,
  input  logic                          s_axil_awvalid,
  output logic                          s_axil_awready,
  input  logic [DATA_WR_WIDTH-1:0]      s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]         s_axil_wstrb,
  input  logic                          s_axil_wvalid,
  output logic                          s_axil_wready,
  output logic [1:0]                    s_axil_bresp,
  output logic                          s_axil_bvalid,
  input  logic                          s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0]    s_axil_araddr,
  input  logic [2:0]                    s_axil_arprot,
  input  logic                          s_axil_arvalid,
  output logic                          s_axil_arready,
  output logic [DATA_RD_WIDTH-1:0]      s_axil_rdata,
  output logic [1:0]                    s_axil_rresp,
  output logic                          s_axil_rvalid,
  input  logic                          s_axil_rready,
  output logic                          mm2s_ren,
  output logic [AXI_ADDR_WIDTH-LSB-1:0] mm2s_addr,
  input  logic [AXI_WIDTH-1:0]          mm2s_data,
  output logic                          s2mm_wen,
  output logic [AXI_ADDR_WIDTH-LSB-1:0] s2mm_addr,
  output logic [AXI_WIDTH-1:0]          s2mm_data,
  output logic [AXI_WIDTH/8-1:0]        s2mm_strb
);
  localparam int WA = AXI_ADDR_WIDTH - LSB;
  localparam int CW = WA + 1;
  localparam int NB = AXI_WIDTH / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [DATA_WR_WIDTH-1:0] regs_q [8];
  logic                     bvalid_q, rvalid_q;
  logic [DATA_RD_WIDTH-1:0] rdata_q;
  logic [WA-1:0]            src_q, src_d, dst_q, dst_d;
  logic [CW-1:0]            beats_q, beats_d, rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            beats_new;
  logic [LSB-1:0]           rem_q, rem_d;
  logic                     wen_q, launch, done_set, busy, wr_hs, rd_hs, last_wr;
  logic [2:0]               wr_idx;
  logic                     unused_bits;

  assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                         s_axil_awaddr[AXIL_ADDR_WIDTH-1:5], s_axil_awaddr[1:0],
                         s_axil_araddr[AXIL_ADDR_WIDTH-1:5], s_axil_araddr[1:0]};

  assign wr_hs          = s_axil_awvalid & s_axil_wvalid & ~bvalid_q;
  assign rd_hs          = s_axil_arvalid & ~rvalid_q;
  assign s_axil_awready = wr_hs;
  assign s_axil_wready  = wr_hs;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = 2'b00;
  assign s_axil_arready = rd_hs;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = 2'b00;
  assign wr_idx         = s_axil_awaddr[4:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (wr_hs) bvalid_q <= 1'b1;
      else if (s_axil_bready) bvalid_q <= 1'b0;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= regs_q[s_axil_araddr[4:2]];
      end else if (s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Bus writes are placed last so a START landing on the launch cycle re-arms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      if (launch)   regs_q[0][0] <= 1'b0;
      if (done_set) regs_q[1][0] <= 1'b1;
      if (wr_hs && wr_idx != 3'd1 && !(wr_idx == 3'd0 && busy)) begin
        for (int b = 0; b < STRB_WIDTH; b++)
          if (s_axil_wstrb[b]) regs_q[wr_idx][8*b +: 8] <= s_axil_wdata[8*b +: 8];
        if (wr_idx == 3'd0 && s_axil_wstrb[0] && s_axil_wdata[0]) regs_q[1][0] <= 1'b0;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign launch    = (state_q == IDLE) && regs_q[0][0];
  assign beats_new = CW'(regs_q[4][AXI_ADDR_WIDTH-1:LSB]) + CW'(|regs_q[4][LSB-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      beats_q  <= '0;
      rem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      beats_q  <= beats_d;
      rem_q    <= rem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      wen_q    <= (state_q == RUN);
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    beats_d  = beats_q;
    rem_d    = rem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    done_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (regs_q[0][0]) begin
          src_d    = regs_q[2][AXI_ADDR_WIDTH-1:LSB];
          dst_d    = regs_q[3][AXI_ADDR_WIDTH-1:LSB];
          beats_d  = beats_new;
          rem_d    = regs_q[4][LSB-1:0];
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          if (beats_new == '0) done_set = 1'b1;
          else state_d = RUN;
        end
      end
      RUN: begin
        rd_ptr_d = rd_ptr_q + CW'(1);
        if (rd_ptr_q == beats_q - CW'(1)) state_d = FLUSH;
      end
      FLUSH: begin
        state_d  = IDLE;
        done_set = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (wen_q) wr_ptr_d = wr_ptr_q + CW'(1);
  end

  assign mm2s_ren  = (state_q == RUN);
  assign mm2s_addr = src_q + rd_ptr_q[WA-1:0];
  assign s2mm_wen  = wen_q;
  assign s2mm_addr = dst_q + wr_ptr_q[WA-1:0];
  assign s2mm_data = mm2s_data;
  assign last_wr   = (wr_ptr_q == beats_q - CW'(1));

  always_comb begin
    s2mm_strb = '1;
    if (last_wr && rem_q != '0)
      for (int b = 0; b < NB; b++) s2mm_strb[b] = (b < int'(rem_q));
  end

endmodule

// File: tb/tb_top_ram.sv
// Directed bench for top_ram: register file access, copy timing, partial
// strobes, zero-length transfers, busy-time writes and mid-transfer reset.
module tb_top_ram;
  logic         clk = 1'b0;
  logic         rst;
  logic [39:0]  s_axil_awaddr, s_axil_araddr;
  logic [2:0]   s_axil_awprot, s_axil_arprot;
  logic         s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [31:0]  s_axil_wdata, s_axil_rdata;
  logic [3:0]   s_axil_wstrb;
  logic [1:0]   s_axil_bresp, s_axil_rresp;
  logic         s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic         s_axil_rvalid, s_axil_rready;
  logic         mm2s_ren, s2mm_wen;
  logic [27:0]  mm2s_addr, s2mm_addr;
  logic [127:0] mm2s_data = '0;
  logic [127:0] s2mm_data;
  logic [15:0]  s2mm_strb;

  top_ram dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .mm2s_ren(mm2s_ren), .mm2s_addr(mm2s_addr), .mm2s_data(mm2s_data),
    .s2mm_wen(s2mm_wen), .s2mm_addr(s2mm_addr), .s2mm_data(s2mm_data), .s2mm_strb(s2mm_strb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  logic [127:0] mem [0:1023];
  always @(posedge clk) begin
    if (mm2s_ren) mm2s_data <= mem[mm2s_addr[9:0]];
    if (s2mm_wen)
      for (int b = 0; b < 16; b++)
        if (s2mm_strb[b]) mem[s2mm_addr[9:0]][8*b +: 8] <= s2mm_data[8*b +: 8];
  end

  int          ren_cyc[$], wen_cyc[$];
  logic [27:0] ren_addr[$], wen_addr[$];
  logic [15:0] wen_strb[$];
  always @(negedge clk) begin
    if (mm2s_ren) begin ren_cyc.push_back(cyc); ren_addr.push_back(mm2s_addr); end
    if (s2mm_wen) begin
      wen_cyc.push_back(cyc); wen_addr.push_back(s2mm_addr); wen_strb.push_back(s2mm_strb);
    end
  end

  task automatic clear_mon();
    ren_cyc.delete(); ren_addr.delete(); wen_cyc.delete(); wen_addr.delete(); wen_strb.delete();
  endtask

  function automatic logic [127:0] pat(input int i);
    return {4{32'hC0DE_0000 | 32'(i)}};
  endfunction

  task automatic axil_write(input logic [39:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int hs);
    hs = -1;
    s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    for (int i = 0; i < 20 && hs < 0; i++) begin
      @(negedge clk);
      if (s_axil_awready && s_axil_wready) hs = cyc + 1;
      @(posedge clk); #1;
    end
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    check("aw_handshake", hs >= 0, 1'b1);
    if (hs >= 0) begin
      @(negedge clk);
      check("bvalid_bresp", {s_axil_bvalid, s_axil_bresp}, 3'b100);
      @(posedge clk); #1;
    end
  endtask

  // at > 0 pins the read-address handshake to that clock edge
  task automatic axil_read(input logic [39:0] a, input int at, output logic [31:0] d);
    int hs;
    hs = -1;
    d = '0;
    while (cyc < at - 1) begin @(posedge clk); #1; end
    s_axil_araddr = a; s_axil_arvalid = 1'b1;
    for (int i = 0; i < 20 && hs < 0; i++) begin
      @(negedge clk);
      if (s_axil_arready) hs = cyc + 1;
      @(posedge clk); #1;
    end
    s_axil_arvalid = 1'b0;
    check("ar_handshake", hs >= 0, 1'b1);
    if (at > 0) check("ar_edge", hs, at);
    if (hs >= 0) begin
      @(negedge clk);
      check("rvalid_rresp", {s_axil_rvalid, s_axil_rresp}, 3'b100);
      d = s_axil_rdata;
      @(posedge clk); #1;
    end
  endtask

  task automatic rd_expect(input string tag, input logic [39:0] a, input int at,
                           input logic [31:0] exp);
    logic [31:0] d;
    axil_read(a, at, d);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [39:0] a, input logic [31:0] d);
    int hs;
    axil_write(a, d, 4'hF, hs);
  endtask

  task automatic start(output int e0);
    axil_write(40'h0, 32'h1, 4'hF, e0);
  endtask

  int           e0, hs;
  logic [127:0] exp_w;

  initial begin
    rst = 1'b1;
    s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
    s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = 1'b0;
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = (i < 16) ? pat(i) : 128'h0;
    mem[10'h200] = '1;
    mem[10'h201] = '1;

    #12;
    check("reset_outputs", {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp,
                            s_axil_arready, s_axil_rvalid, s_axil_rdata, s_axil_rresp,
                            mm2s_ren, s2mm_wen}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) rd_expect("reset_reg", 40'(i * 4), 0, 32'h0);

    // register file access
    wr(40'h14, 32'hDEAD_BEEF);
    rd_expect("scratch_rw", 40'h14, 0, 32'hDEAD_BEEF);
    axil_write(40'h14, 32'h1122_3344, 4'b0001, hs);
    rd_expect("wstrb_byte0", 40'h14, 0, 32'hDEAD_BE44);
    wr(40'hAB_0000_0018, 32'h5A5A_0001);
    rd_expect("upper_addr_ignored", 40'h18, 0, 32'h5A5A_0001);
    rd_expect("neighbour_untouched", 40'h1C, 0, 32'h0);
    wr(40'h04, 32'hFFFF_FFFF);
    rd_expect("done_read_only", 40'h04, 0, 32'h0);

    // simultaneous write and read of the same word: read sees the old value
    s_axil_awaddr = 40'h14; s_axil_wdata = 32'h0BAD_F00D; s_axil_wstrb = 4'hF;
    s_axil_araddr = 40'h14;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
    @(negedge clk);
    check("dual_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
    @(negedge clk);
    check("dual_read_old", s_axil_rdata, 32'hDEAD_BE44);
    @(posedge clk); #1;
    rd_expect("dual_write_new", 40'h14, 0, 32'h0BAD_F00D);

    // full-word copy: 4 beats, DONE 6 cycles after START
    wr(40'h08, 32'h0); wr(40'h0C, 32'h1000); wr(40'h10, 32'd64);
    clear_mon();
    start(e0);
    rd_expect("full_done", 40'h04, e0 + 7, 32'h1);
    check("full_ren_count", ren_cyc.size(), 4);
    check("full_wen_count", wen_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("full_ren_addr", ren_addr[i], 28'(i));
      check("full_ren_cyc", ren_cyc[i], e0 + 1 + i);
      check("full_wen_addr", wen_addr[i], 28'h100 + 28'(i));
      check("full_wen_cyc", wen_cyc[i], e0 + 2 + i);
      check("full_wen_strb", wen_strb[i], 16'hFFFF);
      check("full_dst_data", mem[10'h100 + 10'(i)], pat(i));
    end
    rd_expect("start_selfclear", 40'h00, 0, 32'h0);

    // partial last beat: 20 bytes, unaligned SRC low bits ignored
    wr(40'h08, 32'h4F); wr(40'h0C, 32'h2000); wr(40'h10, 32'd20);
    clear_mon();
    start(e0);
    rd_expect("part_done_clear", 40'h04, e0 + 4, 32'h0);
    rd_expect("part_done_set", 40'h04, 0, 32'h1);
    check("part_wen_count", wen_cyc.size(), 2);
    check("part_ren_addr0", ren_addr[0], 28'h4);
    check("part_wen_addr0", wen_addr[0], 28'h200);
    check("part_strb0", wen_strb[0], 16'hFFFF);
    check("part_strb1", wen_strb[1], 16'h000F);
    check("part_dst0", mem[10'h200], pat(4));
    exp_w = pat(5);
    exp_w[127:32] = '1;
    check("part_dst1", mem[10'h201], exp_w);

    // zero-length transfer
    wr(40'h10, 32'd0);
    clear_mon();
    start(e0);
    rd_expect("zero_done", 40'h04, e0 + 2, 32'h1);
    repeat (3) begin @(posedge clk); #1; end
    check("zero_no_ren", ren_cyc.size(), 0);
    check("zero_no_wen", wen_cyc.size(), 0);

    // back-to-back, with START and DST written while busy
    wr(40'h08, 32'h0); wr(40'h0C, 32'h3000); wr(40'h10, 32'd64);
    clear_mon();
    start(e0);
    axil_write(40'h00, 32'h1, 4'hF, hs);
    check("busy_start_edge", hs, e0 + 2);
    wr(40'h0C, 32'h3400);
    rd_expect("b2b_done1", 40'h04, e0 + 7, 32'h1);
    repeat (4) begin @(posedge clk); #1; end
    check("busy_start_ignored", ren_cyc.size(), 4);
    check("b2b_wen_addr0", wen_addr[0], 28'h300);
    check("b2b_dst1_data", mem[10'h303], pat(3));
    clear_mon();
    start(e0);
    rd_expect("b2b_done2", 40'h04, e0 + 7, 32'h1);
    check("b2b_wen_addr_new", wen_addr[0], 28'h340);
    check("b2b_dst2_data", mem[10'h342], pat(2));

    // reset in the middle of a 10-beat transfer
    wr(40'h10, 32'd160);
    start(e0);
    @(posedge clk); #1;
    check("pre_reset_running", mm2s_ren, 1'b1);
    rst = 1'b1;
    #1;
    check("reset_mid_outputs", {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp,
                                s_axil_arready, s_axil_rvalid, s_axil_rdata, s_axil_rresp,
                                mm2s_ren, s2mm_wen}, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    repeat (5) begin @(posedge clk); #1; end
    check("reset_no_ren", ren_cyc.size(), 0);
    rd_expect("reset_done", 40'h04, 0, 32'h0);
    rd_expect("reset_bytes", 40'h10, 0, 32'h0);
    rd_expect("reset_dst", 40'h0C, 0, 32'h0);
    rd_expect("reset_scratch", 40'h14, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
